// File: rtl/doodle_pkg.sv
// Shared screen geometry, platform table entry type and spawner FSM encoding.
package doodle_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PLAT_W   = 64;
    localparam int PLAT_GAP = 60;
    localparam int X_SPAN   = SCREEN_W - PLAT_W;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic       moving;
        logic       dir;
    } platform_t;

    typedef enum logic [1:0] {StInit, StIdle, StScroll, StSpawn} state_e;

    // Fold a 10-bit random word into the legal left-x range without a divider.
    function automatic logic [9:0] fold_x(input logic [9:0] r);
        logic [9:0] span;
        span = 10'(X_SPAN);
        return (r < span) ? r : r - span;
    endfunction

endpackage

// File: rtl/platform_spawner.sv
// Platform ring table: scrolls live platforms each frame and refills from the top.
// Define MOVING_PLATFORM_EN to add horizontally moving platforms.
module platform_spawner
    import doodle_pkg::*;
#(
    parameter int unsigned NUM_PLAT = 8,
    parameter int unsigned MAX_DY   = 60
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick,
    input  logic [9:0]                  scroll_dy,
    input  logic [14:0]                 rnd,
    input  logic [$clog2(NUM_PLAT)-1:0] rd_idx,
    output logic [9:0]                  plat_x,
    output logic [9:0]                  plat_y,
    output logic                        plat_valid,
    output logic                        plat_moving,
    output logic                        busy
);

    localparam int unsigned     IdxW    = $clog2(NUM_PLAT);
    localparam logic [9:0]      MaxDy   = 10'(MAX_DY);
    localparam logic [9:0]      XEdge   = 10'(X_SPAN);
    localparam logic [9:0]      XCenter = 10'(X_SPAN / 2);
    localparam logic [10:0]     YLimit  = 11'(SCREEN_H);
    localparam logic signed [10:0] Gap     = 11'(PLAT_GAP);
    localparam logic signed [10:0] TopInit = 11'(SCREEN_H);

    state_e             state_q, state_d;
    logic signed [10:0] top_y_q, top_y_d;
    logic [IdxW-1:0]    tail_q, tail_d;
    logic [IdxW-1:0]    scan_q, scan_d;
    logic [9:0]         dy_q, dy_d;

    logic [9:0] x_q     [NUM_PLAT];
    logic [9:0] x_d     [NUM_PLAT];
    logic [9:0] y_q     [NUM_PLAT];
    logic [9:0] y_d     [NUM_PLAT];
    logic       valid_q [NUM_PLAT];
    logic       valid_d [NUM_PLAT];
`ifdef MOVING_PLATFORM_EN
    logic       moving_q [NUM_PLAT];
    logic       moving_d [NUM_PLAT];
    logic       dir_q    [NUM_PLAT];
    logic       dir_d    [NUM_PLAT];
`endif

    logic               can_spawn;
    logic signed [10:0] new_top;
    logic [10:0]        y_sum;
    platform_t          spawn_ent;
    logic               unused_bits;

    assign can_spawn = (top_y_q >= Gap) && !valid_q[tail_q];
    assign new_top   = top_y_q - Gap;
    assign y_sum     = {1'b0, y_q[scan_q]} + {1'b0, dy_q};

    always_comb begin
        spawn_ent       = '0;
        spawn_ent.x     = fold_x(rnd[9:0]);
        // The very first INIT spawn is the centred starting platform.
        if (state_q == StInit && top_y_q == TopInit) begin
            spawn_ent.x = XCenter;
        end
        spawn_ent.y     = new_top[9:0];
        spawn_ent.valid = 1'b1;
`ifdef MOVING_PLATFORM_EN
        spawn_ent.moving = rnd[14] & rnd[13];
        spawn_ent.dir    = rnd[12];
`endif
    end

    always_comb begin
        state_d = state_q;
        top_y_d = top_y_q;
        tail_d  = tail_q;
        scan_d  = scan_q;
        dy_d    = dy_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
`ifdef MOVING_PLATFORM_EN
        moving_d = moving_q;
        dir_d    = dir_q;
`endif
        case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    dy_d    = (scroll_dy > MaxDy) ? MaxDy : scroll_dy;
                    scan_d  = '0;
                    state_d = StScroll;
                end
            end
            StScroll: begin
                if (valid_q[scan_q]) begin
                    y_d[scan_q] = y_sum[9:0];
                    if (y_sum >= YLimit) begin
                        valid_d[scan_q] = 1'b0;
                    end
`ifdef MOVING_PLATFORM_EN
                    if (moving_q[scan_q]) begin
                        if (dir_q[scan_q]) begin
                            if (x_q[scan_q] > XEdge - 10'd2) begin
                                x_d[scan_q]   = XEdge;
                                dir_d[scan_q] = 1'b0;
                            end else begin
                                x_d[scan_q] = x_q[scan_q] + 10'd2;
                            end
                        end else begin
                            if (x_q[scan_q] < 10'd2) begin
                                x_d[scan_q]   = '0;
                                dir_d[scan_q] = 1'b1;
                            end else begin
                                x_d[scan_q] = x_q[scan_q] - 10'd2;
                            end
                        end
                    end
`endif
                end
                if (scan_q == '0) begin
                    top_y_d = top_y_q + $signed({1'b0, dy_q});
                end
                if (scan_q == IdxW'(NUM_PLAT - 1)) begin
                    state_d = StSpawn;
                end
                scan_d = scan_q + 1'b1;
            end
            StInit, StSpawn: begin
                if (can_spawn) begin
                    x_d[tail_q]     = spawn_ent.x;
                    y_d[tail_q]     = spawn_ent.y;
                    valid_d[tail_q] = spawn_ent.valid;
`ifdef MOVING_PLATFORM_EN
                    moving_d[tail_q] = spawn_ent.moving;
                    dir_d[tail_q]    = spawn_ent.dir;
`endif
                    top_y_d = new_top;
                    tail_d  = tail_q + 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            top_y_q <= TopInit;
            tail_q  <= '0;
            scan_q  <= '0;
            dy_q    <= '0;
            for (int unsigned i = 0; i < NUM_PLAT; i++) begin
                valid_q[i] <= 1'b0;
`ifdef MOVING_PLATFORM_EN
                moving_q[i] <= 1'b0;
                dir_q[i]    <= 1'b0;
`endif
            end
        end else begin
            state_q <= state_d;
            top_y_q <= top_y_d;
            tail_q  <= tail_d;
            scan_q  <= scan_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef MOVING_PLATFORM_EN
            moving_q <= moving_d;
            dir_q    <= dir_d;
`endif
        end
    end

    assign plat_x     = x_q[rd_idx];
    assign plat_y     = y_q[rd_idx];
    assign plat_valid = valid_q[rd_idx];
    assign busy       = (state_q != StIdle);

`ifdef MOVING_PLATFORM_EN
    assign plat_moving = moving_q[rd_idx];
    assign unused_bits = ^{rnd[11:10], new_top[10]};
`else
    assign plat_moving = 1'b0;
    assign unused_bits = ^{rnd[14:10], new_top[10], spawn_ent.moving, spawn_ent.dir};
`endif

endmodule

// File: tb/tb_platform_spawner.sv
// Self-checking bench for platform_spawner: directed vector table plus randomized frames
// checked against a frame-level model of the platform ring.
module tb_platform_spawner;

    localparam int NP = 8;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  scroll_dy  = '0;
    logic [14:0] rnd        = '0;
    logic [2:0]  rd_idx     = '0;
    logic [9:0]  plat_x;
    logic [9:0]  plat_y;
    logic        plat_valid;
    logic        plat_moving;
    logic        busy;

    platform_spawner #(
        .NUM_PLAT (NP),
        .MAX_DY   (60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .scroll_dy   (scroll_dy),
        .rnd         (rnd),
        .rd_idx      (rd_idx),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .plat_valid  (plat_valid),
        .plat_moving (plat_moving),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // rnd word presented in each busy cycle, indexed from the start of the busy burst
    logic [14:0] rnd_seq [64];

    int m_x     [NP];
    int m_y     [NP];
    bit m_valid [NP];
    int m_top;
    int m_tail;

    typedef struct {
        bit tick;
        int dy;
        int rlo;
        int exp_busy;
        int idx;
        int exp_valid;
        int exp_x;
        int exp_y;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_seq(input bit forced, input logic [9:0] lo);
        for (int i = 0; i < 64; i++) begin
            rnd_seq[i] = 15'($urandom);
            if (forced) rnd_seq[i][9:0] = lo;
        end
    endtask

    // Clock through a busy burst; n returns the number of busy cycles seen.
    task automatic run_busy(input bit noisy, output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            rnd    = rnd_seq[n];
            rd_idx = 3'($urandom);
            if (noisy) frame_tick = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #1;
            n++;
        end
        frame_tick = 1'b0;
    endtask

    task automatic apply_frame(input int sd, input bit noisy, output int n);
        scroll_dy  = 10'(sd);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        run_busy(noisy, n);
    endtask

    // Spawn j of a burst uses rnd_seq[base + j].
    task automatic model_spawn(input int base, input bit init, output int n);
        n = 0;
        while (m_top >= 60 && !m_valid[m_tail]) begin
            m_x[m_tail]     = (init && n == 0) ? 288 : int'(rnd_seq[base + n][9:0]) % 576;
            m_y[m_tail]     = m_top - 60;
            m_valid[m_tail] = 1'b1;
            m_top           = m_top - 60;
            m_tail          = (m_tail + 1) % NP;
            n++;
        end
    endtask

    task automatic model_init();
        int n;
        m_top  = 480;
        m_tail = 0;
        for (int i = 0; i < NP; i++) m_valid[i] = 1'b0;
        model_spawn(0, 1'b1, n);
    endtask

    task automatic model_frame(input int sd, output int nsp);
        int dy;
        dy = (sd > 60) ? 60 : sd;
        for (int i = 0; i < NP; i++) begin
            if (m_valid[i]) begin
                m_y[i] = m_y[i] + dy;
                if (m_y[i] >= 480) m_valid[i] = 1'b0;
            end
        end
        m_top = m_top + dy;
        model_spawn(NP, 1'b0, nsp);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < NP; i++) begin
            rd_idx = 3'(i);
            @(negedge clk);
            check($sformatf("%s_valid[%0d]", tag, i), 32'(plat_valid), 32'(m_valid[i]));
            if (m_valid[i]) begin
                check($sformatf("%s_x[%0d]", tag, i), 32'(plat_x), m_x[i]);
                check($sformatf("%s_y[%0d]", tag, i), 32'(plat_y), m_y[i]);
            end
`ifndef MOVING_PLATFORM_EN
            check($sformatf("%s_moving[%0d]", tag, i), 32'(plat_moving), 0);
`endif
        end
    endtask

    task automatic run_init(input string tag);
        int n;
        fill_seq(1'b0, '0);
        rst        = 1'b1;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_busy_after_rst"}, 32'(busy), 1);
        run_busy(1'b0, n);
        check({tag, "_busy_cycles"}, n, 9);
        model_init();
        check_table(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // tick, dy, rnd[9:0], busy cycles, read idx, valid, x (-1 = don't care), y
        tbl[0] = '{1'b1,  30,    0,  9, 0, 1,  288, 450};
        tbl[1] = '{1'b0,   0,    0, -1, 7, 1,   -1,  30};
        tbl[2] = '{1'b1,  30, 1000, 10, 0, 1,  424,   0};
        tbl[3] = '{1'b0,   0,    0, -1, 1, 1,   -1, 420};
        tbl[4] = '{1'b1, 500,  575, 10, 1, 1,  575,   0};
        tbl[5] = '{1'b0,   0,    0, -1, 0, 1,  424,  60};
        tbl[6] = '{1'b0,   0,    0, -1, 2, 1,   -1, 420};
        tbl[7] = '{1'b1,   0,    0,  9, 7, 1,   -1, 120};

        repeat (2) @(posedge clk);
        #1;
        run_init("init");

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].tick) begin
                fill_seq(1'b1, 10'(tbl[r].rlo));
                apply_frame(tbl[r].dy, 1'b0, n);
                check($sformatf("vec%0d_busy_cycles", r), n, tbl[r].exp_busy);
            end
            rd_idx = 3'(tbl[r].idx);
            @(negedge clk);
            check($sformatf("vec%0d_valid", r), 32'(plat_valid), tbl[r].exp_valid);
            if (tbl[r].exp_x >= 0) check($sformatf("vec%0d_x", r), 32'(plat_x), tbl[r].exp_x);
            check($sformatf("vec%0d_y", r), 32'(plat_y), tbl[r].exp_y);
        end

        // Reset in the middle of a scroll pass must leave the plain INIT layout.
        fill_seq(1'b0, '0);
        scroll_dy  = 10'd30;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        run_init("midrst");

        for (int f = 0; f < 40; f++) begin
            int sd;
            int got_n;
            int exp_n;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("rand%0d_idle", f), 32'(busy), 0);
            fill_seq($urandom_range(0, 3) == 0, 10'($urandom_range(560, 1023)));
            sd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(61, 1023))
                                             : int'($urandom_range(0, 60));
            apply_frame(sd, 1'b1, got_n);
            model_frame(sd, exp_n);
            check($sformatf("rand%0d_busy_cycles", f), got_n, 9 + exp_n);
            check_table($sformatf("rand%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
